// File: rtl/multdiv_seq.sv
// ---------------------------------------------------------------------------
// multdiv_seq : sequential signed 32-bit multiply / divide unit.
//
// Sits next to the single-cycle ALU. MUL uses radix-2 Booth and DIV uses
// restoring division on magnitudes. Both take exactly ITER iteration cycles
// plus one DONE cycle, so every operation has the same fixed latency.
//
// Ports
//   clock           in   rising-edge clock
//   reset_n         in   asynchronous active-low reset
//   data_operandA   in   multiplicand / dividend (sampled on start edges only)
//   data_operandB   in   multiplier / divisor    (sampled on start edges only)
//   ctrl_MULT       in   start pulse for multiply (wins over ctrl_DIV)
//   ctrl_DIV        in   start pulse for divide
//   data_result     out  low word of product, or signed quotient (held)
//   data_exception  out  overflow or divide-by-zero flag (held)
//   data_resultRDY  out  one-cycle pulse when result/exception are fresh
//   dbg_state       out  current FSM state (IDLE=0, MUL=1, DIV=2, DONE=3)
//
// Handshake: a start is any rising edge with ctrl_MULT or ctrl_DIV high; it
// latches the operands and aborts whatever was in flight (the aborted op never
// pulses RDY). data_resultRDY rises exactly 33 edges after the last start edge
// and stays high for one cycle. A start on that same edge is accepted; the
// completing operation still delivers its pulse.
// ---------------------------------------------------------------------------
module multdiv_seq #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [5:0] LAST_CNT = 6'(ITER);

    state_t             state_q;
    logic [5:0]         cnt_q;
    logic [WIDTH-1:0]   a_q;        // latched operand A (Booth multiplicand, sign source)
    logic [WIDTH-1:0]   b_q;        // latched operand B (divisor, sign source)
    logic [WIDTH:0]     hi_q;       // MUL: accumulator, DIV: partial remainder
    logic [WIDTH-1:0]   lo_q;       // MUL: multiplier,  DIV: dividend / quotient
    logic               qm1_q;      // Booth q(-1)
    logic [WIDTH-1:0]   result_q;
    logic               exc_q;
    logic               rdy_q;

    // Booth step
    logic [WIDTH:0]     a_ext;
    logic [WIDTH:0]     booth_sum;
    logic [WIDTH:0]     mul_hi_d;
    logic [WIDTH-1:0]   mul_lo_d;
    logic               mul_qm1_d;
    logic [WIDTH:0]     mul_top;
    logic               mul_exc_d;

    // Restoring divide step
    logic [WIDTH-1:0]   a_in_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_trial;
    logic [WIDTH:0]     div_hi_d;
    logic [WIDTH-1:0]   div_lo_d;
    logic               div_bzero;
    logic               div_ovf;
    logic               div_exc_d;
    logic [WIDTH-1:0]   div_res_d;

    logic               start;

    assign start = ctrl_MULT | ctrl_DIV;

    always_comb begin
        a_ext     = {a_q[WIDTH-1], a_q};
        booth_sum = hi_q;
        case ({lo_q[0], qm1_q})
            2'b01:   booth_sum = hi_q + a_ext;
            2'b10:   booth_sum = hi_q - a_ext;
            default: booth_sum = hi_q;
        endcase
        // Arithmetic right shift of the whole {acc, mplr, q-1} register.
        mul_hi_d  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        mul_lo_d  = {booth_sum[0], lo_q[WIDTH-1:1]};
        mul_qm1_d = lo_q[0];

        // Product P = {hi_q[WIDTH-1:0], lo_q}; the low word is only a valid
        // signed result when P[63:31] is a pure sign extension.
        mul_top   = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        mul_exc_d = !((&mul_top) || (~|mul_top));
    end

    always_comb begin
        a_in_mag  = data_operandA[WIDTH-1] ? ({WIDTH{1'b0}} - data_operandA) : data_operandA;
        b_mag     = b_q[WIDTH-1] ? ({WIDTH{1'b0}} - b_q) : b_q;

        div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        // One extra bit so the trial difference's sign is never ambiguous.
        div_trial = {1'b0, div_shift} - {2'b00, b_mag};
        div_hi_d  = div_trial[WIDTH+1] ? div_shift : div_trial[WIDTH:0];
        div_lo_d  = {lo_q[WIDTH-2:0], ~div_trial[WIDTH+1]};

        div_bzero = (b_q == {WIDTH{1'b0}});
        div_ovf   = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_q);
        div_exc_d = div_bzero || div_ovf;
        if (div_exc_d) begin
            div_res_d = {WIDTH{1'b0}};
        end else if (a_q[WIDTH-1] ^ b_q[WIDTH-1]) begin
            div_res_d = {WIDTH{1'b0}} - lo_q;
        end else begin
            div_res_d = lo_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            hi_q     <= {(WIDTH+1){1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            qm1_q    <= 1'b0;
            result_q <= {WIDTH{1'b0}};
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            case (state_q)
                S_IDLE: ;
                S_MUL: begin
                    if (cnt_q == LAST_CNT) begin
                        state_q  <= S_DONE;
                        result_q <= lo_q;
                        exc_q    <= mul_exc_d;
                        rdy_q    <= 1'b1;
                    end else begin
                        hi_q  <= mul_hi_d;
                        lo_q  <= mul_lo_d;
                        qm1_q <= mul_qm1_d;
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                S_DIV: begin
                    if (cnt_q == LAST_CNT) begin
                        state_q  <= S_DONE;
                        result_q <= div_res_d;
                        exc_q    <= div_exc_d;
                        rdy_q    <= 1'b1;
                    end else begin
                        hi_q  <= div_hi_d;
                        lo_q  <= div_lo_d;
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            // A start overrides the sequencing above but not the completion
            // outputs, so a start on the RDY edge keeps that pulse.
            if (start) begin
                state_q <= ctrl_MULT ? S_MUL : S_DIV;
                cnt_q   <= 6'd0;
                a_q     <= data_operandA;
                b_q     <= data_operandB;
                hi_q    <= {(WIDTH+1){1'b0}};
                lo_q    <= ctrl_MULT ? data_operandB : a_in_mag;
                qm1_q   <= 1'b0;
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign dbg_state      = state_q;

endmodule
